// File: rtl/atm_cmd_sequencer.sv
// Session sequencer: card/keypad events -> 3-bit command stream, PIN check, retries, lockout.
// Optional inactivity timeout built only when ATM_SEQ_TIMEOUT_EN is defined.
module atm_cmd_sequencer #(
  parameter int unsigned PIN_DIGITS     = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    card_in,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    key_enter,
  input  logic                    key_cancel,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  output logic [2:0]              cmd_out,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  input  logic [2:0]              rsp_code,
  input  logic                    rsp_valid,
  output logic [2:0]              last_rsp,
  output logic [1:0]              tries,
  output logic                    locked,
  output logic                    busy
);

  localparam int PW    = 4 * PIN_DIGITS;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [2:0] CMD_CARD_OK    = 3'b000;
  localparam logic [2:0] CMD_PIN_BAD    = 3'b001;
  localparam logic [2:0] CMD_PIN_OK     = 3'b010;
  localparam logic [2:0] CMD_TXN_REQ    = 3'b011;
  localparam logic [2:0] CMD_TXN_CANCEL = 3'b100;
  localparam logic [2:0] CMD_EJECT      = 3'b101;
  localparam logic [2:0] CMD_CARD_LOST  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_PIN, S_CHECK, S_SELECT, S_WAIT, S_LOCK
  } state_t;

  state_t             state_q, state_d, ret_q, ret_d;
  logic [2:0]         cmd_q, cmd_d, rsp_q, rsp_d;
  logic               vld_q, vld_d, pend_q, pend_d, lost_q, lost_d;
  logic [PW-1:0]      pin_q, pin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         tries_q, tries_d;
  logic [LCK_W-1:0]   lock_q, lock_d;
  logic               card_q, card_prev_q;

  logic               card_rise, card_fall, lost, cancel, digit_ok, pin_match, timeout_hit;
  logic               launch;
  logic [2:0]         launch_cmd;
  state_t             launch_ret;

`ifdef ATM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_active;

  assign to_active   = (state_q == S_PIN) || (state_q == S_SELECT);
  assign timeout_hit = to_active && (32'(to_cnt_q) == TIMEOUT_CYCLES - 1);

  // Any other state holds the counter at zero, so every entry starts fresh.
  always_ff @(posedge clock) begin
    if (reset || !to_active || key_valid || key_enter || key_cancel) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  assign card_rise = card_q & ~card_prev_q;
  assign card_fall = ~card_q & card_prev_q;
  assign lost      = lost_q | card_fall;
  assign cancel    = key_cancel | timeout_hit;
  assign digit_ok  = key_valid && (key_digit <= 4'd9);
  assign pin_match = (cnt_q == CNT_W'(PIN_DIGITS)) && (pin_q == stored_pin);

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cmd_d      = cmd_q;
    vld_d      = vld_q;
    pend_d     = pend_q;
    pin_d      = pin_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    lock_d     = lock_q;
    rsp_d      = rsp_q;
    lost_d     = lost_q;
    launch     = 1'b0;
    launch_cmd = CMD_CARD_OK;
    launch_ret = S_IDLE;

    // A removal seen mid-command is remembered and acted on once back in a session state.
    if (state_q == S_IDLE) begin
      lost_d = 1'b0;
    end else if (card_fall && (state_q != S_LOCK)) begin
      lost_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (card_rise) begin
          launch = 1'b1; launch_cmd = CMD_CARD_OK; launch_ret = S_PIN;
        end
      end
      S_SEND: begin
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (cmd_ready) begin
          vld_d = 1'b0;
          if (pend_q) begin
            cmd_d  = CMD_EJECT;
            pend_d = 1'b0;
          end else begin
            state_d = ret_q;
          end
        end
      end
      S_PIN: begin
        if (lost) begin
          launch = 1'b1; launch_cmd = CMD_CARD_LOST; launch_ret = S_IDLE;
        end else if (cancel) begin
          launch = 1'b1; launch_cmd = CMD_TXN_CANCEL; launch_ret = S_IDLE; pend_d = 1'b1;
        end else if (key_enter) begin
          state_d = S_CHECK;
        end else if (digit_ok && (32'(cnt_q) < PIN_DIGITS)) begin
          pin_d = PW'({pin_q, key_digit});
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        launch = 1'b1;
        if (pin_match) begin
          launch_cmd = CMD_PIN_OK; launch_ret = S_SELECT;
        end else if (32'(tries_q) + 32'd1 < MAX_TRIES) begin
          launch_cmd = CMD_PIN_BAD; launch_ret = S_PIN;
          tries_d    = tries_q + 2'd1;
          cnt_d      = '0;
          pin_d      = '0;
        end else begin
          launch_cmd = CMD_EJECT; launch_ret = S_LOCK;
          lock_d     = '0;
        end
      end
      S_SELECT: begin
        if (lost) begin
          launch = 1'b1; launch_cmd = CMD_CARD_LOST; launch_ret = S_IDLE;
        end else if (cancel) begin
          launch = 1'b1; launch_cmd = CMD_TXN_CANCEL; launch_ret = S_IDLE; pend_d = 1'b1;
        end else if (key_enter) begin
          launch = 1'b1; launch_cmd = CMD_TXN_REQ; launch_ret = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lost) begin
          launch = 1'b1; launch_cmd = CMD_CARD_LOST; launch_ret = S_IDLE;
        end else if (rsp_valid) begin
          rsp_d  = rsp_code;
          launch = 1'b1; launch_cmd = CMD_EJECT; launch_ret = S_IDLE;
        end
      end
      S_LOCK: begin
        if (32'(lock_q) == LOCK_CYCLES - 1) begin
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q + LCK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d = S_SEND;
      vld_d   = 1'b1;
      cmd_d   = launch_cmd;
      ret_d   = launch_ret;
    end

    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      tries_d = '0;
      cnt_d   = '0;
      pin_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      cmd_q       <= CMD_CARD_OK;
      vld_q       <= 1'b0;
      pend_q      <= 1'b0;
      pin_q       <= '0;
      cnt_q       <= '0;
      tries_q     <= '0;
      lock_q      <= '0;
      rsp_q       <= '0;
      lost_q      <= 1'b0;
      card_q      <= 1'b0;
      card_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cmd_q       <= cmd_d;
      vld_q       <= vld_d;
      pend_q      <= pend_d;
      pin_q       <= pin_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      lock_q      <= lock_d;
      rsp_q       <= rsp_d;
      lost_q      <= lost_d;
      card_q      <= card_in;
      card_prev_q <= card_q;
    end
  end

  assign cmd_out   = cmd_q;
  assign cmd_valid = vld_q;
  assign last_rsp  = rsp_q;
  assign tries     = tries_q;
  assign locked    = (state_q == S_LOCK);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/atm_cmd_sequencer.md
# atm_cmd_sequencer

Front-end session sequencer for the ATM: turns card-slot and keypad events into the 3-bit command stream consumed by the ATM controller FSM, and collects that FSM's response code. Owns PIN entry, PIN comparison, retry counting, lockout and (optionally) the inactivity timeout. Sits between the debounced keypad/card-slot logic and the ATM controller's `x_in`/`y_out` interface, acting as the initiator of that interface.

## Interface
- `PIN_DIGITS`, 4, number of BCD digits in a PIN.
- `MAX_TRIES`, 3, wrong-PIN attempts allowed per card session before lockout.
- `LOCK_CYCLES`, 1024, lockout duration in clock cycles.
- `TIMEOUT_CYCLES`, 4096, inactivity limit in PIN/SELECT states.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `card_in`  in  1  card-present level.
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  4  BCD digit; values >9 are ignored.
- `key_enter`  in  1  one-cycle enter strobe.
- `key_cancel`  in  1  one-cycle cancel strobe.
- `stored_pin`  in  4*PIN_DIGITS  reference PIN, digit 0 in the MS nibble.
- `cmd_out`  out  3  command code.
- `cmd_valid`  out  1  command offered.
- `cmd_ready`  in  1  controller accepts command.
- `rsp_code`  in  3  controller response code.
- `rsp_valid`  in  1  response strobe.
- `last_rsp`  out  3  most recent captured `rsp_code`.
- `tries`  out  2  wrong-PIN count in the current session.
- `locked`  out  1  high in LOCKOUT.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Command codes: 000 CARD_OK, 001 PIN_BAD, 010 PIN_OK, 011 TXN_REQ, 100 TXN_CANCEL, 101 EJECT, 110 CARD_LOST. 111 is never issued.
- Send rule: `cmd_out` is loaded and `cmd_valid` asserted together. Both are held stable until a clock edge with `cmd_valid && cmd_ready`. `cmd_valid` drops on the following cycle unless another command is queued by the FSM.
- States: IDLE, SEND, PIN_ENTRY, CHECK, SELECT, WAIT_RSP, LOCKOUT. SEND carries a registered "return-to" state.
- IDLE: a rising edge of `card_in` (registered previous value) sends CARD_OK, then enters PIN_ENTRY. On entry to IDLE, `tries` and the digit count are cleared.
- PIN_ENTRY:
  - `key_valid` with a digit of 9 or less shifts the digit in. The digit count saturates at PIN_DIGITS; later digits are dropped.
  - `key_enter` goes to CHECK.
- CHECK (one cycle): a match needs digit count == PIN_DIGITS and equal digits.
  - Match: send PIN_OK, then SELECT.
  - Mismatch with `tries`+1 < MAX_TRIES: increment `tries`, clear digits, send PIN_BAD, then PIN_ENTRY.
  - Otherwise: send EJECT, then LOCKOUT.
- SELECT: `key_enter` sends TXN_REQ, then WAIT_RSP.
- WAIT_RSP: `rsp_valid` captures `rsp_code` into `last_rsp`, sends EJECT, then IDLE. Keypad input is ignored here.
- LOCKOUT: counts LOCK_CYCLES, then IDLE. `card_in` and keypad are ignored.
- `key_cancel` in PIN_ENTRY or SELECT sends TXN_CANCEL, then EJECT, then IDLE.
- Priority in one cycle: cancel, then enter, then digit. A digit arriving together with enter is discarded.
- `card_in` falling in PIN_ENTRY, SELECT or WAIT_RSP sends CARD_LOST, then IDLE, with no EJECT. While in SEND, the in-flight command completes first, then CARD_LOST is sent.
- `reset` mid-handshake drops `cmd_valid` immediately, with no completion.

## Timing
- Reset values: `cmd_out`=000, `cmd_valid`=0, `last_rsp`=000, `tries`=0, `locked`=0, `busy`=0; state IDLE.
- `card_in` first sampled high at edge N: `cmd_valid`=1 with CARD_OK after edge N+1.
- `key_enter` at edge N: CHECK during cycle N..N+1; `cmd_valid` asserted after edge N+1.
- A command accepted at edge M: next command, if any, earliest valid after edge M+1.
- LOCKOUT entered at edge L: `locked` is high for exactly LOCK_CYCLES cycles; IDLE follows.
- `cmd_ready` held high permanently: one command per 2 cycles, at most.

## Configuration
- `ATM_SEQ_TIMEOUT_EN` defined:
  - An inactivity counter runs in PIN_ENTRY and SELECT.
  - It resets on any `key_valid`, `key_enter` or `key_cancel`, and on state entry.
  - Reaching TIMEOUT_CYCLES acts exactly as `key_cancel`.
- Not defined: no counter is built, and the states wait indefinitely. `TIMEOUT_CYCLES` is unused.

## Test plan
- Card insert, keys 1,2,3,4 with `stored_pin`=16'h1234, enter, enter, `rsp_valid` with `rsp_code`=3'b110, `cmd_ready`=1 -> commands 000,010,011,101; `last_rsp`=110; `busy`=0 at end.
- Three wrong PINs (5,5,5,5) -> commands 000,001,001,101; `tries` reads 2 before the third CHECK; `locked`=1 for 1024 cycles; card insert during lockout issues nothing.
- `cmd_ready` held low 10 cycles after PIN_OK is offered -> `cmd_out`=010 and `cmd_valid`=1 stable all 10 cycles; exactly one transfer.
- `card_in` dropped in SELECT -> single 110 command, then IDLE; no 101 issued.
- Same-cycle `key_cancel` and `key_enter` in SELECT -> 100 then 101; no 011.
- With `ATM_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, idle in PIN_ENTRY -> 100 then 101 after 16 cycles; without the macro, no command after 1000 cycles.
